sdc_data_sequencer: RTL and testbench

SDC_DATA_SEQUENCER -- requirements
Module: sdc_data_sequencer

---
 rtl/sdc_data_sequencer_if.sv | 34 +++
 rtl/sdc_data_sequencer.sv | 154 +++++++++++++++
 tb/tb_sdc_data_sequencer.sv | 250 +++++++++++++++++++++++++
 3 files changed

// File: rtl/sdc_data_sequencer_if.sv
// Handshake bundle between an SD-card data path controller and its beat sequencer.
// blockCount exists only when SDC_SEQ_MULTIBLOCK_EN is defined.
interface sdc_data_sequencer_if;
    logic        start;
    logic        count;
    logic        abort;
`ifdef SDC_SEQ_MULTIBLOCK_EN
    logic [15:0] blockCount;
`endif
    logic        shift;
    logic        load;
    logic        byteDone;
    logic        blockDone;
    logic        crcDone;
    logic        done;
    logic        busy;
    logic [2:0]  phase;

    modport master (
`ifdef SDC_SEQ_MULTIBLOCK_EN
        output blockCount,
`endif
        output start, count, abort,
        input  shift, load, byteDone, blockDone, crcDone, done, busy, phase
    );

    modport slave (
`ifdef SDC_SEQ_MULTIBLOCK_EN
        input  blockCount,
`endif
        input  start, count, abort,
        output shift, load, byteDone, blockDone, crcDone, done, busy, phase
    );
endinterface

// File: rtl/sdc_data_sequencer.sv
// Beat sequencer for SD-card block data: start bit, data beats, CRC beats, end bit.
// Define SDC_SEQ_MULTIBLOCK_EN to repeat blocks per blockCount; otherwise one block per transfer.
module sdc_data_sequencer #(
    parameter int BLOCK_BYTES = 512,
    parameter int BUS_WIDTH   = 1,
    parameter int CRC_BITS    = 16
) (
    input  logic                 clk,
    input  logic                 resetCounter,
    sdc_data_sequencer_if.slave  seq_bus
);
    localparam int BPB   = 8 / BUS_WIDTH;
    localparam int DB    = BLOCK_BYTES * BPB;
    localparam int BPB_W = $clog2(BPB);
    // Widened when CRC_BITS exceeds the data beat count so the CRC phase never wraps.
    localparam int CW    = (($clog2(DB) > $clog2(CRC_BITS)) ? $clog2(DB) : $clog2(CRC_BITS)) + 1;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_START = 3'd1,
        S_DATA  = 3'd2,
        S_CRC   = 3'd3,
        S_END   = 3'd4
    } state_t;

    state_t        r_state, w_state_nxt;
    logic [CW-1:0] r_cnt, w_cnt_nxt;
    logic [15:0]   r_blocks_left, w_blocks_nxt;
    logic [15:0]   w_block_count;
    logic          r_load, r_byte_done, r_block_done, r_crc_done, r_done, r_busy;
    logic          w_load, w_byte_done, w_block_done, w_crc_done, w_done;
    logic          w_byte_end, w_data_last, w_crc_last;

`ifdef SDC_SEQ_MULTIBLOCK_EN
    assign w_block_count = (seq_bus.blockCount == 16'd0) ? 16'd1 : seq_bus.blockCount;
`else
    assign w_block_count = 16'd1;
`endif

    assign w_byte_end  = (r_cnt[BPB_W-1:0] == BPB_W'(BPB - 1));
    assign w_data_last = (r_cnt == CW'(DB - 1));
    assign w_crc_last  = (r_cnt == CW'(CRC_BITS - 1));

    always_comb begin
        // NOTE: every target gets a default first so no path through the case infers a latch.
        w_state_nxt  = r_state;
        w_cnt_nxt    = r_cnt;
        w_blocks_nxt = r_blocks_left;
        w_load       = 1'b0;
        w_byte_done  = 1'b0;
        w_block_done = 1'b0;
        w_crc_done   = 1'b0;
        w_done       = 1'b0;

        if (seq_bus.abort) begin
            w_state_nxt  = S_IDLE;
            w_cnt_nxt    = '0;
            w_blocks_nxt = '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (seq_bus.start) begin
                        w_state_nxt  = S_START;
                        w_cnt_nxt    = '0;
                        w_blocks_nxt = w_block_count;
                        w_load       = 1'b1;
                    end
                end
                S_START: begin
                    if (seq_bus.count) begin
                        w_state_nxt = S_DATA;
                        w_cnt_nxt   = '0;
                    end
                end
                S_DATA: begin
                    if (seq_bus.count) begin
                        if (w_data_last) begin
                            w_state_nxt  = S_CRC;
                            w_cnt_nxt    = '0;
                            w_byte_done  = 1'b1;
                            w_block_done = 1'b1;
                        end else begin
                            w_cnt_nxt = r_cnt + CW'(1);
                            if (w_byte_end) begin
                                w_byte_done = 1'b1;
                                w_load      = 1'b1;
                            end
                        end
                    end
                end
                S_CRC: begin
                    if (seq_bus.count) begin
                        if (w_crc_last) begin
                            w_state_nxt = S_END;
                            w_cnt_nxt   = '0;
                            w_crc_done  = 1'b1;
                        end else begin
                            w_cnt_nxt = r_cnt + CW'(1);
                        end
                    end
                end
                S_END: begin
                    if (seq_bus.count) begin
                        w_cnt_nxt = '0;
                        if (r_blocks_left > 16'd1) begin
                            w_state_nxt  = S_START;
                            w_blocks_nxt = r_blocks_left - 16'd1;
                            w_load       = 1'b1;
                        end else begin
                            w_state_nxt  = S_IDLE;
                            w_blocks_nxt = '0;
                            w_done       = 1'b1;
                        end
                    end
                end
                default: w_state_nxt = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        // NOTE: non-blocking updates let every register sample pre-edge values; reset is tested inside the clocked block because it is synchronous.
        if (resetCounter) begin
            r_state       <= S_IDLE;
            r_cnt         <= '0;
            r_blocks_left <= '0;
            r_load        <= 1'b0;
            r_byte_done   <= 1'b0;
            r_block_done  <= 1'b0;
            r_crc_done    <= 1'b0;
            r_done        <= 1'b0;
            r_busy        <= 1'b0;
        end else begin
            r_state       <= w_state_nxt;
            r_cnt         <= w_cnt_nxt;
            r_blocks_left <= w_blocks_nxt;
            r_load        <= w_load;
            r_byte_done   <= w_byte_done;
            r_block_done  <= w_block_done;
            r_crc_done    <= w_crc_done;
            r_done        <= w_done;
            r_busy        <= (w_state_nxt != S_IDLE);
        end
    end

    assign seq_bus.shift     = seq_bus.count & ((r_state == S_DATA) || (r_state == S_CRC));
    assign seq_bus.load      = r_load;
    assign seq_bus.byteDone  = r_byte_done;
    assign seq_bus.blockDone = r_block_done;
    assign seq_bus.crcDone   = r_crc_done;
    assign seq_bus.done      = r_done;
    assign seq_bus.busy      = r_busy;
    assign seq_bus.phase     = r_state;
endmodule

// File: tb/tb_sdc_data_sequencer.sv
// Directed bench: a 1-lane and a 4-lane sequencer driven by the same stimulus, pulses counted per lane width.
// Multi-block checks are compiled in when SDC_SEQ_MULTIBLOCK_EN is defined.
module tb_sdc_data_sequencer;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst, start, count, abort, clr;
`ifdef SDC_SEQ_MULTIBLOCK_EN
    logic [15:0] block_count;
`endif

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;
    int t0      = 0;

    // Index 0 = 1-lane instance, index 1 = 4-lane instance.
    int n_byte[2], n_blk[2], n_crc[2], n_done[2], n_load[2], n_busy[2];
    int c_done[2], c_blk[2], c_crc[2];

    sdc_data_sequencer_if if1();
    sdc_data_sequencer_if if4();

    assign if1.start = start;
    assign if1.count = count;
    assign if1.abort = abort;
    assign if4.start = start;
    assign if4.count = count;
    assign if4.abort = abort;
`ifdef SDC_SEQ_MULTIBLOCK_EN
    assign if1.blockCount = block_count;
    assign if4.blockCount = block_count;
`endif

    sdc_data_sequencer #(.BLOCK_BYTES(512), .BUS_WIDTH(1), .CRC_BITS(16)) u_dut1 (
        .clk          (clk),
        .resetCounter (rst),
        .seq_bus      (if1.slave)
    );

    sdc_data_sequencer #(.BLOCK_BYTES(512), .BUS_WIDTH(4), .CRC_BITS(16)) u_dut4 (
        .clk          (clk),
        .resetCounter (rst),
        .seq_bus      (if4.slave)
    );

    logic [1:0] v_byte, v_blk, v_crc, v_done, v_load, v_busy;
    assign v_byte = {if4.byteDone,  if1.byteDone};
    assign v_blk  = {if4.blockDone, if1.blockDone};
    assign v_crc  = {if4.crcDone,   if1.crcDone};
    assign v_done = {if4.done,      if1.done};
    assign v_load = {if4.load,      if1.load};
    assign v_busy = {if4.busy,      if1.busy};

    // cyc is the index of the most recent rising edge; c_* hold the edge index of a first pulse.
    always @(posedge clk) begin
        #1;
        cyc <= cyc + 1;
        for (int i = 0; i < 2; i++) begin
            if (clr) begin
                n_byte[i] <= 0; n_blk[i] <= 0; n_crc[i] <= 0; n_done[i] <= 0;
                n_load[i] <= 0; n_busy[i] <= 0;
                c_done[i] <= 0; c_blk[i] <= 0; c_crc[i] <= 0;
            end else begin
                if (v_byte[i]) n_byte[i] <= n_byte[i] + 1;
                if (v_load[i]) n_load[i] <= n_load[i] + 1;
                if (v_busy[i]) n_busy[i] <= n_busy[i] + 1;
                if (v_blk[i]) begin
                    n_blk[i] <= n_blk[i] + 1;
                    if (n_blk[i] == 0) c_blk[i] <= cyc + 1;
                end
                if (v_crc[i]) begin
                    n_crc[i] <= n_crc[i] + 1;
                    if (n_crc[i] == 0) c_crc[i] <= cyc + 1;
                end
                if (v_done[i]) begin
                    n_done[i] <= n_done[i] + 1;
                    if (n_done[i] == 0) c_done[i] <= cyc + 1;
                end
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    task automatic expect_counts(input int i, input string run, input int bytes, input int blks,
                                 input int crcs, input int dones, input int loads);
        string w;
        w = (i == 0) ? "bw1" : "bw4";
        check($sformatf("%s_%s_byteDone", run, w),  n_byte[i], bytes);
        check($sformatf("%s_%s_blockDone", run, w), n_blk[i],  blks);
        check($sformatf("%s_%s_crcDone", run, w),   n_crc[i],  crcs);
        check($sformatf("%s_%s_done", run, w),      n_done[i], dones);
        check($sformatf("%s_%s_load", run, w),      n_load[i], loads);
    endtask

    task automatic clear_mon();
        @(negedge clk);
        clr = 1'b1;
        @(negedge clk);
        clr = 1'b0;
    endtask

    // t0 is the index of the edge that samples start.
    task automatic start_xfer();
        @(negedge clk);
        start = 1'b1;
        t0    = cyc + 1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_done(input int budget, input bit toggle, input int pulse_at);
        int k = 0;
        while ((n_done[0] == 0 || n_done[1] == 0) && k < budget) begin
            @(negedge clk);
            k++;
            if (toggle) count = ~count;
            start = (k == pulse_at);
        end
        start = 1'b0;
        check("done_within_budget", k < budget, 1);
        repeat (2) @(negedge clk);
    endtask

    initial begin
        #4000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        rst   = 1'b1;
        start = 1'b1;
        count = 1'b1;
        abort = 1'b0;
        clr   = 1'b1;
`ifdef SDC_SEQ_MULTIBLOCK_EN
        block_count = 16'd1;
`endif
        // Reset must win over a simultaneous start and count.
        repeat (3) @(negedge clk);
        check("reset_outputs_bw1", {if1.load, if1.byteDone, if1.blockDone, if1.crcDone, if1.done,
                                    if1.busy, if1.shift, if1.phase}, 0);
        check("reset_outputs_bw4", {if4.load, if4.byteDone, if4.blockDone, if4.crcDone, if4.done,
                                    if4.busy, if4.shift, if4.phase}, 0);
        start = 1'b0;
        rst   = 1'b0;
        clr   = 1'b0;

        // count alone in IDLE does nothing.
        repeat (5) @(negedge clk);
        check("idle_count_phase", if1.phase, 0);
        check("idle_count_busy",  if1.busy, 0);

        // Full block, count held high.
        clear_mon();
        start_xfer();
        wait_done(6000, 1'b0, -1);
        expect_counts(0, "full", 512, 1, 1, 1, 512);
        expect_counts(1, "full", 512, 1, 1, 1, 512);
        check("full_bw1_done_latency",   c_done[0] - t0 + 1, 4115);
        check("full_bw1_blockDone_edge", c_blk[0] - t0, 4097);
        check("full_bw1_crcDone_edge",   c_crc[0] - t0, 4113);
        check("full_bw1_busy_cycles",    n_busy[0], 4114);
        check("full_bw4_done_latency",   c_done[1] - t0 + 1, 1043);
        check("full_bw4_blockDone_edge", c_blk[1] - t0, 1025);
        check("full_bw4_busy_cycles",    n_busy[1], 1042);

        // count toggling every cycle, with a stray start pulse while both are in DATA.
        clear_mon();
        count = 1'b0;
        start_xfer();
        count = 1'b1;
        wait_done(12000, 1'b1, 300);
        count = 1'b1;
        expect_counts(0, "half", 512, 1, 1, 1, 512);
        expect_counts(1, "half", 512, 1, 1, 1, 512);
        check("half_bw1_done_latency", c_done[0] - t0 + 1, 8228);
        check("half_bw4_done_latency", c_done[1] - t0 + 1, 2084);

        // Abort on data beat 103, which closes a byte in both widths, so its pulses must be swallowed.
        clear_mon();
        start_xfer();
        repeat (104) @(negedge clk);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        check("abort_bw1_phase", if1.phase, 0);
        check("abort_bw1_busy",  if1.busy, 0);
        check("abort_bw4_phase", if4.phase, 0);
        check("abort_bw4_busy",  if4.busy, 0);
        check("abort_bw1_byteDone", n_byte[0], 12);
        check("abort_bw1_load",     n_load[0], 13);
        check("abort_bw4_byteDone", n_byte[1], 51);
        check("abort_bw4_load",     n_load[1], 52);
        repeat (20) @(negedge clk);
        check("abort_bw1_no_done", n_done[0], 0);
        check("abort_bw4_no_done", n_done[1], 0);
        check("abort_bw1_no_blockDone", n_blk[0], 0);

        clear_mon();
        start_xfer();
        wait_done(6000, 1'b0, -1);
        expect_counts(0, "after_abort", 512, 1, 1, 1, 512);
        check("after_abort_bw1_done_latency", c_done[0] - t0 + 1, 4115);

        // Reset on CRC beat 5 of the 1-lane instance.
        clear_mon();
        start_xfer();
        repeat (4102) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("crc_reset_outputs_bw1", {if1.load, if1.byteDone, if1.blockDone, if1.crcDone, if1.done,
                                        if1.busy, if1.shift, if1.phase}, 0);
        check("crc_reset_blockDone_seen", n_blk[0], 1);
        rst = 1'b0;
        repeat (30) @(negedge clk);
        check("crc_reset_no_crcDone", n_crc[0], 0);
        check("crc_reset_no_done",    n_done[0], 0);
        check("crc_reset_idle_busy",  if1.busy, 0);

`ifdef SDC_SEQ_MULTIBLOCK_EN
        block_count = 16'd3;
        clear_mon();
        start_xfer();
        wait_done(15000, 1'b0, -1);
        expect_counts(0, "multi3", 1536, 3, 3, 1, 1536);
        expect_counts(1, "multi3", 1536, 3, 3, 1, 1536);
        check("multi3_bw1_done_latency", c_done[0] - t0 + 1, 12343);
        check("multi3_bw4_done_latency", c_done[1] - t0 + 1, 3127);

        block_count = 16'd0;
        clear_mon();
        start_xfer();
        wait_done(6000, 1'b0, -1);
        expect_counts(0, "multi0", 512, 1, 1, 1, 512);
        check("multi0_bw1_done_latency", c_done[0] - t0 + 1, 4115);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
